licznik_updown_mod_n: RTL
=========================

// Module: licznik_updown_mod_n
// PURPOSE
//  Parametrised up/down modulo-N counter with synchronous clear, parallel load,
//  clock enable and a cascadable terminal-count output. Next-generation general
//  counter for lab timers, dividers and multi-digit (BCD-style) counter chains.
//  TC of one stage drives CE of the next.
// PARAMETERS
//  N      10                    modulus; count range 0..N-1; N>=2
//  WIDTH  (N>2)?$clog2(N):1     width of D and Q
//  INIT   0                     value applied by RST and CLR; must be < N
//  PRESC  4                     prescaler ratio, used only with LICZNIK_PRESCALER_EN; >=1
// PORTS
//  CLK      in   1      rising-edge clock
//  RST      in   1      asynchronous, active-low reset
//  CE       in   1      count enable
//  UP       in   1      1 = count up, 0 = count down
//  CLR      in   1      synchronous clear to INIT
//  LOAD     in   1      synchronous parallel load of D
//  D        in   WIDTH  load value
//  Q        out  WIDTH  count value (registered)
//  TC       out  1      terminal count, combinational: step_en & (UP ? Q==N-1 : Q==0)
//  LOAD_ERR out  1      registered one-cycle pulse: LOAD with D>=N was clamped
// BEHAVIOUR
//  - RST low (async): Q=INIT, LOAD_ERR=0, prescaler=0. Release is synchronous to CLK.
//  - Per-edge priority: CLR > LOAD > count. CLR and LOAD together: CLR wins.
//    LOAD_ERR=0 in that cycle.
//  - CLR: Q<=INIT next edge, independent of CE.
//  - LOAD: Q<=D next edge, independent of CE. If D>=N then Q<=N-1 and LOAD_ERR=1
//    for exactly one cycle. Otherwise LOAD_ERR=0.
//  - Count: if step_en, Q<=UP ? (Q==N-1 ? 0 : Q+1) : (Q==0 ? N-1 : Q-1).
//  - Without prescaler, step_en = CE.
//  - Latency: one cycle from the control input to the new Q.
//  - TC has zero latency and follows UP, CE and Q combinationally. It is 0 during
//    CLR or LOAD cycles.
//  - UP may change on any cycle. The direction is sampled at the edge that performs
//    the step. No dead cycle on reversal.
//  - Arithmetic is done in WIDTH+1 bits. Q never leaves 0..N-1, including when N is
//    not a power of 2.
//  - CE low: Q holds and TC=0.
// CONFIGURATION
//  Macro LICZNIK_PRESCALER_EN:
//  - Defined: an internal prescaler counts CE-high cycles modulo PRESC.
//    step_en = CE & (pcnt==PRESC-1). CLR, LOAD and RST zero pcnt.
//  - Not defined: no prescaler logic, PRESC is ignored, step_en = CE.
//  - Ports are identical in both builds.
// STRUCTURE
//  - Package licznik_pkg:
//    - function cnt_width(n): safe clog2, minimum 1.
//    - localparam enum for the priority encoding {OP_HOLD, OP_CLR, OP_LOAD, OP_STEP}.
//  - Sub-module licznik_prescaler (PRESC param; CLK, RST, CE, SCLR -> STEP).
//    Instantiated only under LICZNIK_PRESCALER_EN.
//  - Top: a combinational op decode plus one Q register and one LOAD_ERR register.
// TESTING
//  1. N=10, UP=1, CE=1 from reset for 12 edges -> Q 0..9,0,1. TC=1 only while Q==9.
//  2. N=10, UP=0, CE=1 from Q=0 -> Q 9,8,7. TC=1 at Q==0.
//     Flip UP at Q=7 -> next edge Q=8.
//  3. LOAD=1, D=7 -> Q=7, LOAD_ERR=0. LOAD=1, D=12 -> Q=9, LOAD_ERR=1 for one cycle.
//  4. CLR=1 and LOAD=1 with D=5, CE=1 on the same edge -> Q=INIT=0, TC=0, LOAD_ERR=0.
//  5. RST low asynchronously mid-count at Q=6 (between edges) -> Q=0 immediately.
//     Holds through edges while low. Counting resumes on the first edge after release.
//  6. With LICZNIK_PRESCALER_EN, PRESC=3, N=4, CE=1 -> Q steps every 3rd edge: 0,0,0,1,1,1,2.
//     LOAD mid-period restarts the period.
//  Cascade check: two N=10 stages, TC0->CE1 -> stage 1 increments on the edge where
//  stage 0 wraps 9->0.

Source files
------------

// File: rtl/licznik_pkg.sv
// Shared helpers for the licznik up/down modulo-N counter family.
// Width helper and the per-edge operation encoding used by the top.
package licznik_pkg;

   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Priority order is CLR > LOAD > STEP; HOLD when nothing applies.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_CLR  = 2'd1,
      OP_LOAD = 2'd2,
      OP_STEP = 2'd3
   } op_e;

endpackage

// File: rtl/licznik_prescaler.sv
// Prescaler for licznik: counts CE-high cycles modulo PRESC, STEP on the last one.
// Used only when LICZNIK_PRESCALER_EN is defined.
module licznik_prescaler
   import licznik_pkg::*;
#(
   parameter int PRESC = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic CE,
   input  logic SCLR,
   output logic STEP
);

   localparam int              PW   = cnt_width(PRESC);
   localparam logic [PW-1:0]   LAST = PW'(PRESC - 1);

   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;

   always_comb begin
      pcnt_d = pcnt_q;
      if (SCLR) begin
         pcnt_d = '0;
      end else if (CE) begin
         pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   assign STEP = CE & (pcnt_q == LAST);

endmodule

// File: rtl/licznik_updown_mod_n.sv
// Up/down modulo-N counter with sync clear, clamped parallel load and cascadable TC.
// Optional CE prescaler is built in when LICZNIK_PRESCALER_EN is defined.
module licznik_updown_mod_n
   import licznik_pkg::*;
#(
   parameter int N     = 10,
   parameter int WIDTH = cnt_width(N),
   parameter int INIT  = 0,
   parameter int PRESC = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic             UP,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             LOAD_ERR
);

   // Compares run one bit wider so N itself is representable even at 2**WIDTH.
   localparam logic [WIDTH:0]   N_W    = (WIDTH + 1)'(N);
   localparam logic [WIDTH:0]   LAST_W = (WIDTH + 1)'(N - 1);
   localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(N - 1);
   localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             err_q;
   logic             err_d;
   logic             step_en;
   op_e              op;

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] d_ext;

   assign q_ext = {1'b0, q_q};
   assign d_ext = {1'b0, D};

`ifdef LICZNIK_PRESCALER_EN
   licznik_prescaler #(
      .PRESC (PRESC)
   ) u_presc (
      .CLK  (CLK),
      .RST  (RST),
      .CE   (CE),
      .SCLR (CLR | LOAD),
      .STEP (step_en)
   );
`else
   assign step_en = CE;
`endif

   always_comb begin
      op = OP_HOLD;
      if (CLR) begin
         op = OP_CLR;
      end else if (LOAD) begin
         op = OP_LOAD;
      end else if (step_en) begin
         op = OP_STEP;
      end
   end

   always_comb begin
      q_d   = q_q;
      err_d = 1'b0;
      case (op)
         OP_CLR: begin
            q_d = INIT_Q;
         end
         OP_LOAD: begin
            if (d_ext >= N_W) begin
               q_d   = LAST_Q;
               err_d = 1'b1;
            end else begin
               q_d = D;
            end
         end
         OP_STEP: begin
            if (UP) begin
               q_d = (q_ext == LAST_W) ? '0 : WIDTH'(q_ext + 1'b1);
            end else begin
               q_d = (q_ext == '0) ? LAST_Q : WIDTH'(q_ext - 1'b1);
            end
         end
         default: begin
            q_d = q_q;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q_q   <= INIT_Q;
         err_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
      end
   end

   // TC is forced low on CLR/LOAD cycles because op is only OP_STEP otherwise.
   assign TC       = (op == OP_STEP) & (UP ? (q_ext == LAST_W) : (q_ext == '0));
   assign Q        = q_q;
   assign LOAD_ERR = err_q;

endmodule
